// File: rtl/rot_tile_wide.sv
// Rotatable WIDTH-bit logic tile: orientation/function from a serial shadow config chain
// with explicit commit, scannable state register and an optional registered loop breaker.
module rot_tile_wide #(
   parameter int unsigned WIDTH = 4,
   parameter bit          LB    = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cfg_shift,
   input  logic             cfg_in,
   input  logic             cfg_commit,
   output logic             cfg_out,
   input  logic             in_se,
   input  logic             in_sc,
   output logic             out_sc,
   input  logic             in_lb,
   input  logic [WIDTH-1:0] in_t,
   input  logic [WIDTH-1:0] in_r,
   input  logic [WIDTH-1:0] in_b,
   input  logic [WIDTH-1:0] in_l,
   output logic [WIDTH-1:0] out_t,
   output logic [WIDTH-1:0] out_r,
   output logic [WIDTH-1:0] out_b,
   output logic [WIDTH-1:0] out_l
);

   localparam int unsigned CFG_W = 5;

   logic [CFG_W-1:0] shadow_q, shadow_d;
   logic [1:0]       fn_q;
   logic             d_q, h_q, v_q;
   logic [WIDTH-1:0] st_q, st_d;

   logic [WIDTH-1:0] vt, vb, hr, hl, dh, dv;
   logic [WIDTH-1:0] gn_raw, gh_raw, gn, gh, oh, ov;

   // Shadow chain shifts freely; the active config only moves on commit (pre-shift shadow).
   always_comb begin
      shadow_d = shadow_q;
      if (cfg_shift) shadow_d = {shadow_q[CFG_W-2:0], cfg_in};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shadow_q <= '0;
         fn_q     <= 2'b00;
         d_q      <= 1'b0;
         h_q      <= 1'b0;
         v_q      <= 1'b0;
      end else begin
         shadow_q <= shadow_d;
         if (cfg_commit) {fn_q, d_q, h_q, v_q} <= shadow_q;
      end
   end

   assign cfg_out = shadow_q[CFG_W-1];

   assign vt = v_q ? in_b : in_t;
   assign vb = v_q ? in_t : in_b;
   assign hr = h_q ? in_l : in_r;
   assign hl = h_q ? in_r : in_l;
   assign dh = d_q ? vt : hl;
   assign dv = d_q ? hl : vt;

   always_comb begin
      gn_raw = '0;
      case (fn_q)
         2'b00:   gn_raw = ~(hr & vb);
         2'b01:   gn_raw = ~(hr | vb);
         2'b10:   gn_raw = hr ^ vb;
         default: gn_raw = hr & vb;
      endcase
   end

   assign gh_raw = dh;

   // Truncating the concatenation drops the old MSB, which also covers WIDTH=1.
   always_comb begin
      st_d = dv;
      if (in_se) st_d = WIDTH'({st_q, in_sc});
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) st_q <= '0;
      else     st_q <= st_d;
   end

   assign out_sc = st_q[WIDTH-1];

   generate
      if (LB) begin : g_lb_reg
         logic [WIDTH-1:0] gn_q, gh_q;

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               gn_q <= '0;
               gh_q <= '0;
            end else if (!in_lb) begin
               gn_q <= gn_raw;
               gh_q <= gh_raw;
            end
         end

         assign gn = gn_q;
         assign gh = gh_q;
      end else begin : g_lb_comb
         logic unused_lb;
         assign unused_lb = in_lb;
         assign gn        = gn_raw;
         assign gh        = gh_raw;
      end
   endgenerate

   assign oh    = d_q ? gn : st_q;
   assign ov    = d_q ? st_q : gn;
   assign out_t = v_q ? gh : ov;
   assign out_b = v_q ? ov : gh;
   assign out_r = h_q ? oh : gh;
   assign out_l = h_q ? gh : oh;

endmodule

// File: tb/tb_rot_tile_wide.sv
// Bench for rot_tile_wide: one LB=1 and one LB=0 tile on shared stimulus, checked
// against a side-array reference model plus directed corner sequences.
module tb_rot_tile_wide;

   localparam int unsigned W = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic         cfg_shift, cfg_in, cfg_commit, in_se, in_sc, in_lb;
   logic [W-1:0] in_t, in_r, in_b, in_l;

   logic         a_cfg, a_sc, b_cfg, b_sc;
   logic [W-1:0] a_t, a_r, a_b, a_l, b_t, b_r, b_b, b_l;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state: shadow, active {fn1,fn0,d,h,v}, state reg, loop-breaker regs
   logic [4:0]   m_sh, m_act;
   logic [W-1:0] m_st, m_gn, m_gh;

   typedef struct packed {
      logic [W-1:0] hr, vb, dh, dv;
   } remap_t;

   typedef struct {
      logic [4:0]   cfg;
      logic [W-1:0] t, r, b, l;
      logic [15:0]  exp;
   } vec_t;

   rot_tile_wide #(.WIDTH(W), .LB(1'b1)) u_lb1 (
      .clk(clk), .rst(rst), .cfg_shift(cfg_shift), .cfg_in(cfg_in), .cfg_commit(cfg_commit),
      .cfg_out(a_cfg), .in_se(in_se), .in_sc(in_sc), .out_sc(a_sc), .in_lb(in_lb),
      .in_t(in_t), .in_r(in_r), .in_b(in_b), .in_l(in_l),
      .out_t(a_t), .out_r(a_r), .out_b(a_b), .out_l(a_l)
   );

   rot_tile_wide #(.WIDTH(W), .LB(1'b0)) u_lb0 (
      .clk(clk), .rst(rst), .cfg_shift(cfg_shift), .cfg_in(cfg_in), .cfg_commit(cfg_commit),
      .cfg_out(b_cfg), .in_se(in_se), .in_sc(in_sc), .out_sc(b_sc), .in_lb(in_lb),
      .in_t(in_t), .in_r(in_r), .in_b(in_b), .in_l(in_l),
      .out_t(b_t), .out_r(b_r), .out_b(b_b), .out_l(b_l)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   // Truth-table lookup indexed by {a,b} per lane
   function automatic logic [W-1:0] fn_eval(input logic [1:0] fn, input logic [W-1:0] a,
                                            input logic [W-1:0] b);
      logic [3:0]   tt;
      logic [W-1:0] res;
      case (fn)
         2'b00:   tt = 4'b0111;
         2'b01:   tt = 4'b0001;
         2'b10:   tt = 4'b0110;
         default: tt = 4'b1000;
      endcase
      for (int i = 0; i < int'(W); i++) res[i] = tt[{a[i], b[i]}];
      return res;
   endfunction

   // Sides as array 0=T 1=R 2=B 3=L; v swaps T/B, h swaps R/L
   function automatic remap_t in_remap(input logic [4:0] cfg, input logic [W-1:0] t,
                                       input logic [W-1:0] r, input logic [W-1:0] b,
                                       input logic [W-1:0] l);
      logic [W-1:0] p[4];
      logic [W-1:0] tmp;
      remap_t       res;
      p[0] = t; p[1] = r; p[2] = b; p[3] = l;
      if (cfg[0]) begin tmp = p[0]; p[0] = p[2]; p[2] = tmp; end
      if (cfg[1]) begin tmp = p[1]; p[1] = p[3]; p[3] = tmp; end
      res.hr = p[1];
      res.vb = p[2];
      res.dh = cfg[2] ? p[0] : p[3];
      res.dv = cfg[2] ? p[3] : p[0];
      return res;
   endfunction

   function automatic logic [15:0] out_remap(input logic [4:0] cfg, input logic [W-1:0] gn,
                                             input logic [W-1:0] gh, input logic [W-1:0] st);
      logic [W-1:0] o[4];
      logic [W-1:0] tmp;
      o[0] = cfg[2] ? st : gn;
      o[1] = gh;
      o[2] = gh;
      o[3] = cfg[2] ? gn : st;
      if (cfg[0]) begin tmp = o[0]; o[0] = o[2]; o[2] = tmp; end
      if (cfg[1]) begin tmp = o[1]; o[1] = o[3]; o[3] = tmp; end
      return {o[0], o[1], o[2], o[3]};
   endfunction

   // Settled outputs after one clock with stable inputs under a committed config
   function automatic logic [15:0] exp_out(input logic [4:0] cfg, input logic [W-1:0] t,
                                           input logic [W-1:0] r, input logic [W-1:0] b,
                                           input logic [W-1:0] l);
      remap_t rm = in_remap(cfg, t, r, b, l);
      return out_remap(cfg, fn_eval(cfg[4:3], rm.hr, rm.vb), rm.dh, rm.dv);
   endfunction

   function automatic logic [15:0] model_out(input bit reg_lb);
      remap_t       rm = in_remap(m_act, in_t, in_r, in_b, in_l);
      logic [W-1:0] gn = reg_lb ? m_gn : fn_eval(m_act[4:3], rm.hr, rm.vb);
      logic [W-1:0] gh = reg_lb ? m_gh : rm.dh;
      return out_remap(m_act, gn, gh, m_st);
   endfunction

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_all(input string name);
      chk({name, "/lb1"}, {a_t, a_r, a_b, a_l}, model_out(1'b1));
      chk({name, "/lb0"}, {b_t, b_r, b_b, b_l}, model_out(1'b0));
      chk({name, "/chain"}, {12'h0, a_cfg, a_sc, b_cfg, b_sc},
          {12'h0, m_sh[4], m_st[W-1], m_sh[4], m_st[W-1]});
   endtask

   task automatic model_reset();
      m_sh = '0; m_act = '0; m_st = '0; m_gn = '0; m_gh = '0;
   endtask

   // Advance model and DUT by one edge; returns 2 time units after the edge
   task automatic tick();
      remap_t       rm;
      logic [4:0]   n_sh, n_act;
      logic [W-1:0] n_st, n_gn, n_gh;
      rm    = in_remap(m_act, in_t, in_r, in_b, in_l);
      n_sh  = cfg_shift ? {m_sh[3:0], cfg_in} : m_sh;
      n_act = cfg_commit ? m_sh : m_act;
      n_st  = in_se ? {m_st[W-2:0], in_sc} : rm.dv;
      n_gn  = in_lb ? m_gn : fn_eval(m_act[4:3], rm.hr, rm.vb);
      n_gh  = in_lb ? m_gh : rm.dh;
      @(posedge clk);
      m_sh = n_sh; m_act = n_act; m_st = n_st; m_gn = n_gn; m_gh = n_gh;
      #2;
   endtask

   task automatic shift_word(input logic [4:0] w);
      for (int i = 4; i >= 0; i--) begin
         cfg_shift = 1'b1;
         cfg_in    = w[i];
         tick();
      end
      cfg_shift = 1'b0;
      cfg_in    = 1'b0;
   endtask

   task automatic load_cfg(input logic [4:0] w);
      shift_word(w);
      cfg_commit = 1'b1;
      tick();
      cfg_commit = 1'b0;
   endtask

   task automatic set_lanes(input logic [W-1:0] t, input logic [W-1:0] r,
                            input logic [W-1:0] b, input logic [W-1:0] l);
      in_t = t; in_r = r; in_b = b; in_l = l;
   endtask

   initial begin
      vec_t       tbl[12];
      logic [3:0] scan_bits;

      for (int i = 0; i < 8; i++) begin
         tbl[i].cfg = {2'b00, 3'(i)};
         tbl[i].t = 4'h1; tbl[i].r = 4'h2; tbl[i].b = 4'h4; tbl[i].l = 4'h8;
      end
      for (int i = 8; i < 12; i++) begin
         tbl[i].cfg = 5'($urandom);
         tbl[i].t = 4'($urandom); tbl[i].r = 4'($urandom);
         tbl[i].b = 4'($urandom); tbl[i].l = 4'($urandom);
      end
      for (int i = 0; i < 12; i++)
         tbl[i].exp = exp_out(tbl[i].cfg, tbl[i].t, tbl[i].r, tbl[i].b, tbl[i].l);

      // Reset with random inputs
      rst = 1'b1;
      set_lanes(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
      cfg_shift = 1'($urandom); cfg_in = 1'($urandom); cfg_commit = 1'($urandom);
      in_se = 1'($urandom); in_sc = 1'($urandom); in_lb = 1'($urandom);
      #1;
      model_reset();
      chk("rst_out_lb1", {a_t, a_r, a_b, a_l}, 16'h0);
      chk("rst_chain", {12'h0, a_cfg, a_sc, b_cfg, b_sc}, 16'h0);
      check_all("rst");
      cfg_shift = 1'b0; cfg_commit = 1'b0; in_se = 1'b0; in_sc = 1'b0;
      in_lb = 1'b1; in_t = 4'h0;
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("hold_zero", {a_t, a_r, a_b, a_l}, 16'h0);
         check_all("hold");
      end

      // AND config, NAND held before commit
      set_lanes(4'hF, 4'hF, 4'hF, 4'h0);
      in_lb = 1'b0;
      shift_word(5'b11000);
      chk("cfg_out_after_shift", {15'h0, a_cfg}, 16'h1);
      chk("nand_before_commit", {12'h0, a_t}, 16'h0);
      check_all("pre_commit");
      cfg_commit = 1'b1;
      tick();
      cfg_commit = 1'b0;
      check_all("commit_edge");
      tick();
      chk("and_out_t", {12'h0, a_t}, 16'hF);
      check_all("and1");
      tick();
      chk("and_out_l", {12'h0, a_l}, 16'hF);
      check_all("and2");

      // Commit together with shift takes the pre-shift shadow
      set_lanes(4'h3, 4'h5, 4'hA, 4'hC);
      shift_word(5'b00001);
      cfg_shift = 1'b1; cfg_in = 1'b1; cfg_commit = 1'b1;
      tick();
      cfg_shift = 1'b0; cfg_in = 1'b0; cfg_commit = 1'b0;
      tick();
      chk("shift_commit_v_lb1", {a_t, a_r, a_b, a_l}, exp_out(5'b00001, in_t, in_r, in_b, in_l));
      chk("shift_commit_v_lb0", {b_t, b_r, b_b, b_l}, exp_out(5'b00001, in_t, in_r, in_b, in_l));
      cfg_commit = 1'b1;
      tick();
      cfg_commit = 1'b0;
      tick();
      chk("commit_vh_lb1", {a_t, a_r, a_b, a_l}, exp_out(5'b00011, in_t, in_r, in_b, in_l));
      check_all("commit_vh");

      // Scan 1,0,1,1 with h=v=1, d=0 so out_r shows the state register
      scan_bits = 4'b1011;
      in_se = 1'b1;
      for (int i = 3; i >= 0; i--) begin
         in_sc = scan_bits[i];
         tick();
         check_all("scan");
      end
      chk("scan_out_sc", {15'h0, a_sc}, 16'h1);
      chk("scan_reg", {12'h0, a_r}, 16'h000B);
      in_se = 1'b0; in_sc = 1'b0;
      tick();
      chk("capture_dv", {12'h0, a_r}, {12'h0, in_b});
      check_all("capture");

      // Orientation / function sweep
      in_lb = 1'b0;
      for (int i = 0; i < 12; i++) begin
         set_lanes(tbl[i].t, tbl[i].r, tbl[i].b, tbl[i].l);
         load_cfg(tbl[i].cfg);
         tick();
         chk("sweep_lb1", {a_t, a_r, a_b, a_l}, tbl[i].exp);
         chk("sweep_lb0", {b_t, b_r, b_b, b_l}, tbl[i].exp);
         if (i == 0) chk("sweep_id_const", {a_t, a_r, a_b, a_l}, 16'hF881);
         check_all("sweep");
      end

      // LB=0: same-cycle propagation, in_lb ignored
      set_lanes(4'h1, 4'h2, 4'h4, 4'h8);
      load_cfg(5'b00000);
      tick();
      in_l = 4'h9;
      #1;
      chk("lb0_comb_out_r", {12'h0, b_r}, 16'h0009);
      check_all("lb0_comb");
      in_lb = 1'b1;
      #1;
      check_all("lb0_lb_ignored");

      // Reset three bits into a config shift
      in_lb = 1'b0;
      cfg_shift = 1'b1; cfg_in = 1'b1;
      for (int i = 0; i < 3; i++) tick();
      rst = 1'b1;
      #1;
      model_reset();
      cfg_shift = 1'b0;
      set_lanes(4'h0, 4'h0, 4'h0, 4'h0);
      #1;
      chk("rst_mid_lb0", {b_t, b_r, b_b, b_l}, 16'hF000);
      check_all("rst_mid");
      rst = 1'b0;
      cfg_shift = 1'b1;
      for (int i = 0; i < 2; i++) tick();
      cfg_shift = 1'b0; cfg_in = 1'b0;
      chk("rst_lost_shadow", {15'h0, a_cfg}, 16'h0);
      chk("rst_active_zero", {b_t, b_r, b_b, b_l}, 16'hF000);
      check_all("post_rst");

      // Random traffic against the model
      for (int k = 0; k < 400; k++) begin
         set_lanes(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
         cfg_shift  = 1'($urandom);
         cfg_in     = 1'($urandom);
         cfg_commit = ($urandom_range(7) == 0);
         in_se      = ($urandom_range(3) == 0);
         in_sc      = 1'($urandom);
         in_lb      = ($urandom_range(2) == 0);
         if ($urandom_range(63) == 0) begin
            rst = 1'b1;
            #1;
            model_reset();
            check_all("rand_rst");
            rst = 1'b0;
         end
         #1;
         check_all("rand_comb");
         tick();
         check_all("rand_seq");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
